// File: rtl/axis_packetizer.sv
// Frames a valid/ready word stream into packets: one header word, then PKT_LEN payload
// words, with m_last on the final payload word and an 8-bit wrapping sequence number.
module axis_packetizer #(
    parameter int          DATA_WIDTH = 32,
    parameter int          PKT_LEN    = 8,
    parameter logic [7:0]  HDR_TAG    = 8'hA5
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  m_is_hdr,
    output logic [7:0]            pkt_seq,
    output logic                  busy
);

    localparam logic [15:0] LEN16     = 16'(PKT_LEN);
    localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        PAY  = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   m_data_nxt;
    logic                    m_valid_nxt;
    logic                    m_last_nxt;
    logic                    m_is_hdr_nxt;
    logic [7:0]              pkt_seq_nxt;
    logic [15:0]             beat_cnt, beat_cnt_nxt;
    logic                    slot_free;
    logic [DATA_WIDTH-1:0]   hdr_word;

    // Handshake: a word moves on any rising edge where valid && ready; the output
    // register may be reloaded when it is empty or being drained in the same cycle.
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state == PAY) && slot_free;
    assign busy      = (state == PAY) || m_valid;
    assign hdr_word  = DATA_WIDTH'({HDR_TAG, pkt_seq, LEN16});

    always_comb begin
        state_nxt    = state;
        m_data_nxt   = m_data;
        m_valid_nxt  = m_valid;
        m_last_nxt   = m_last;
        m_is_hdr_nxt = m_is_hdr;
        pkt_seq_nxt  = pkt_seq;
        beat_cnt_nxt = beat_cnt;

        if (m_valid && m_ready) begin
            m_valid_nxt  = 1'b0;
            m_last_nxt   = 1'b0;
            m_is_hdr_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                // The header waits for payload to be present so no orphan header is sent.
                if (s_valid && slot_free) begin
                    m_data_nxt   = hdr_word;
                    m_valid_nxt  = 1'b1;
                    m_is_hdr_nxt = 1'b1;
                    m_last_nxt   = 1'b0;
                    beat_cnt_nxt = 16'd0;
                    state_nxt    = PAY;
                end
            end
            PAY: begin
                if (s_valid && s_ready) begin
                    m_data_nxt   = s_data;
                    m_valid_nxt  = 1'b1;
                    m_is_hdr_nxt = 1'b0;
                    m_last_nxt   = (beat_cnt == LAST_BEAT);
                    if (beat_cnt == LAST_BEAT) begin
                        beat_cnt_nxt = 16'd0;
                        pkt_seq_nxt  = pkt_seq + 8'd1;
                        state_nxt    = IDLE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 16'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            m_data   <= '0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_is_hdr <= 1'b0;
            pkt_seq  <= 8'd0;
            beat_cnt <= 16'd0;
        end else begin
            state    <= state_nxt;
            m_data   <= m_data_nxt;
            m_valid  <= m_valid_nxt;
            m_last   <= m_last_nxt;
            m_is_hdr <= m_is_hdr_nxt;
            pkt_seq  <= pkt_seq_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_axis_packetizer.sv
// Bench for axis_packetizer: vector table for the basic framing, stream-level reference
// model for random traffic, and directed sequences for reset and single-word packets.
module tb_axis_packetizer;

    localparam int L = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic        m_is_hdr;
    logic [7:0]  pkt_seq;
    logic        busy;

    logic [31:0] u1_s_data = '0;
    logic        u1_s_valid = 1'b0;
    logic        u1_s_ready;
    logic [31:0] u1_m_data;
    logic        u1_m_valid;
    logic        u1_m_ready = 1'b0;
    logic        u1_m_last;
    logic        u1_m_is_hdr;
    logic [7:0]  u1_pkt_seq;
    logic        u1_busy;

    axis_packetizer #(.DATA_WIDTH(32), .PKT_LEN(L), .HDR_TAG(8'hA5)) dut (
        .aclk(aclk), .areset(areset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_is_hdr(m_is_hdr), .pkt_seq(pkt_seq), .busy(busy)
    );

    axis_packetizer #(.DATA_WIDTH(32), .PKT_LEN(1), .HDR_TAG(8'hA5)) dut1 (
        .aclk(aclk), .areset(areset), .s_data(u1_s_data), .s_valid(u1_s_valid), .s_ready(u1_s_ready),
        .m_data(u1_m_data), .m_valid(u1_m_valid), .m_ready(u1_m_ready), .m_last(u1_m_last),
        .m_is_hdr(u1_m_is_hdr), .pkt_seq(u1_pkt_seq), .busy(u1_busy)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Stream model state: accepted input words, observed output beats {hdr,last,data}.
    logic [31:0] acc_q[$];
    logic [33:0] obs_q[$];
    logic [33:0] u1_obs[$];
    int          model_seq = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    int          beats = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;
    logic        drv_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (s_valid && s_ready) acc_q.push_back(s_data);
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_hold", 64'({m_is_hdr, m_last, m_data}), 64'(prev_word));
            end
            if (m_valid && !m_ready) chk("bp_s_ready", 64'(s_ready), 64'd0);
            if (m_valid && m_ready) begin
                obs_q.push_back({m_is_hdr, m_last, m_data});
                beats++;
                if (beats == 1) first_cyc = cyc;
                last_cyc = cyc;
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_is_hdr, m_last, m_data};
            if (u1_m_valid && u1_m_ready) u1_obs.push_back({u1_m_is_hdr, u1_m_last, u1_m_data});
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        s_valid = 1'b0;
        u1_s_valid = 1'b0;
        m_ready = 1'b0;
        u1_m_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        acc_q.delete();
        obs_q.delete();
        u1_obs.delete();
        model_seq = 0;
        beats = 0;
    endtask

    task automatic send_words(input int n, input int gap_pct);
        int i = 0;
        int guard = 0;
        logic [31:0] w = $urandom();
        while (i < n && guard < 20000) begin
            @(posedge aclk);
            #1;
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = w;
            @(negedge aclk);
            if (s_valid && s_ready) begin
                i++;
                w = $urandom();
            end
            guard++;
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        chk("send_timeout", 64'(i), 64'(n));
        drv_done = 1'b1;
    endtask

    task automatic ready_loop();
        while (!drv_done) begin
            @(posedge aclk);
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end
        m_ready = 1'b1;
    endtask

    task automatic drain();
        m_ready = 1'b1;
        repeat (5) @(posedge aclk);
        #1;
    endtask

    // Reference: every L accepted words form one packet, preceded by a header whose
    // sequence field counts packets since reset modulo 256.
    task automatic check_stream(input string name);
        int k = 0;
        logic [33:0] exp_w;
        logic [33:0] act_w;
        chk({name, "_len"}, 64'(obs_q.size()), 64'(acc_q.size() + acc_q.size() / L));
        for (int i = 0; i < acc_q.size(); i++) begin
            if (i % L == 0) begin
                exp_w = {1'b1, 1'b0, 8'hA5, 8'(model_seq), 16'(L)};
                act_w = (k < obs_q.size()) ? obs_q[k] : 'x;
                chk({name, "_hdr"}, 64'(act_w), 64'(exp_w));
                k++;
            end
            exp_w = {1'b0, (i % L == L - 1), acc_q[i]};
            act_w = (k < obs_q.size()) ? obs_q[k] : 'x;
            chk({name, "_pay"}, 64'(act_w), 64'(exp_w));
            k++;
            if (i % L == L - 1) model_seq = (model_seq + 1) % 256;
        end
        acc_q.delete();
        obs_q.delete();
    endtask

    typedef struct {
        logic        s_valid;
        logic [31:0] s_data;
        logic        m_ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_hdr;
        logic        e_last;
        logic        e_s_ready;
        logic [7:0]  e_seq;
        logic        e_busy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1, 32'd1, 1, 0, 32'd0,        0, 0, 0, 8'd0, 0};
        vecs[1]  = '{1, 32'd1, 1, 1, 32'hA5000004, 1, 0, 1, 8'd0, 1};
        vecs[2]  = '{1, 32'd2, 1, 1, 32'd1,        0, 0, 1, 8'd0, 1};
        vecs[3]  = '{1, 32'd3, 1, 1, 32'd2,        0, 0, 1, 8'd0, 1};
        vecs[4]  = '{1, 32'd4, 1, 1, 32'd3,        0, 0, 1, 8'd0, 1};
        vecs[5]  = '{0, 32'd0, 1, 1, 32'd4,        0, 1, 0, 8'd1, 1};
        vecs[6]  = '{0, 32'd0, 1, 0, 32'd0,        0, 0, 0, 8'd1, 0};
        vecs[7]  = '{1, 32'd5, 0, 0, 32'd0,        0, 0, 0, 8'd1, 0};
        vecs[8]  = '{1, 32'd5, 0, 1, 32'hA5010004, 1, 0, 0, 8'd1, 1};
        vecs[9]  = '{1, 32'd5, 1, 1, 32'hA5010004, 1, 0, 1, 8'd1, 1};
        vecs[10] = '{1, 32'd6, 0, 1, 32'd5,        0, 0, 0, 8'd1, 1};
        vecs[11] = '{1, 32'd6, 1, 1, 32'd5,        0, 0, 1, 8'd1, 1};
        vecs[12] = '{0, 32'd0, 1, 1, 32'd6,        0, 0, 1, 8'd1, 1};
        vecs[13] = '{0, 32'd0, 1, 0, 32'd0,        0, 0, 1, 8'd1, 1};

        // Idle after reset
        do_reset();
        @(negedge aclk);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_is_hdr", 64'(m_is_hdr), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("idle_m_valid", 64'(m_valid), 64'd0);
            chk("idle_s_ready", 64'(s_ready), 64'd0);
            chk("idle_pkt_seq", 64'(pkt_seq), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
        end

        // Vector table: one packet, then backpressure and a mid-packet source gap
        for (int i = 0; i < 14; i++) begin
            @(posedge aclk);
            #1;
            s_valid = vecs[i].s_valid;
            s_data  = vecs[i].s_data;
            m_ready = vecs[i].m_ready;
            @(negedge aclk);
            chk($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_m_data", i), 64'(m_data), 64'(vecs[i].e_data));
                chk($sformatf("vec%0d_m_is_hdr", i), 64'(m_is_hdr), 64'(vecs[i].e_hdr));
                chk($sformatf("vec%0d_m_last", i), 64'(m_last), 64'(vecs[i].e_last));
            end
            chk($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'(vecs[i].e_s_ready));
            chk($sformatf("vec%0d_pkt_seq", i), 64'(pkt_seq), 64'(vecs[i].e_seq));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
        end

        // 300 back-to-back packets: sequence wraps and output never idles
        do_reset();
        m_ready = 1'b1;
        drv_done = 1'b0;
        send_words(300 * L, 0);
        drain();
        chk("tp_beats", 64'(beats), 64'(300 * (L + 1)));
        chk("tp_gapless", 64'(last_cyc - first_cyc + 1), 64'(beats));
        check_stream("tp");
        chk("tp_seq_end", 64'(pkt_seq), 64'(300 % 256));

        // Random source gaps with random downstream backpressure
        drv_done = 1'b0;
        fork
            send_words(1000, 30);
            ready_loop();
        join
        drain();
        check_stream("rnd");
        chk("rnd_seq_end", 64'(pkt_seq), 64'((300 + 250) % 256));
        chk("rnd_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset after two of four payload words
        @(posedge aclk);
        #1;
        s_valid = 1'b1;
        s_data  = 32'h11;
        begin
            int got = 0;
            int guard = 0;
            while (got < 2 && guard < 50) begin
                @(negedge aclk);
                if (s_valid && s_ready) got++;
                @(posedge aclk);
                #1;
                s_data = s_data + 32'h11;
                guard++;
            end
            chk("rst_partial_words", 64'(got), 64'd2);
        end
        #1;
        areset = 1'b1;
        #1;
        chk("arst_m_valid", 64'(m_valid), 64'd0);
        chk("arst_m_data", 64'(m_data), 64'd0);
        chk("arst_m_last", 64'(m_last), 64'd0);
        chk("arst_m_is_hdr", 64'(m_is_hdr), 64'd0);
        chk("arst_pkt_seq", 64'(pkt_seq), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_s_ready", 64'(s_ready), 64'd0);
        do_reset();
        m_ready = 1'b1;
        drv_done = 1'b0;
        send_words(L, 0);
        drain();
        check_stream("after_rst");

        // Single-word packets: header before every payload word, m_last on each
        u1_m_ready = 1'b1;
        begin
            int idx = 0;
            int guard = 0;
            while (idx < 6 && guard < 100) begin
                @(posedge aclk);
                #1;
                u1_s_valid = 1'b1;
                u1_s_data  = 32'h100 + 32'(idx);
                @(negedge aclk);
                if (u1_s_valid && u1_s_ready) idx++;
                guard++;
            end
            @(posedge aclk);
            #1;
            u1_s_valid = 1'b0;
            repeat (4) @(posedge aclk);
            #1;
            chk("len1_words", 64'(idx), 64'd6);
        end
        chk("len1_len", 64'(u1_obs.size()), 64'd12);
        for (int k = 0; k < 6; k++) begin
            logic [33:0] a;
            a = (2 * k < u1_obs.size()) ? u1_obs[2 * k] : 'x;
            chk("len1_hdr", 64'(a), 64'({1'b1, 1'b0, 8'hA5, 8'(k), 16'd1}));
            a = (2 * k + 1 < u1_obs.size()) ? u1_obs[2 * k + 1] : 'x;
            chk("len1_pay", 64'(a), 64'({1'b0, 1'b1, 32'h100 + 32'(k)}));
        end
        chk("len1_seq_end", 64'(u1_pkt_seq), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout act=%0d exp=0", $time);
        $fatal(1, "timeout");
    end

endmodule
